wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter. It issues a registered one-hot grant with a valid/ready handshake and holds the grant across multi-beat transfers until the beat marked last. A per-requester weight sets how many consecutive transfers a requester may win before priority rotates to the next index. It sits in front of shared resources (CAM search port, result bus) wherever several request sources compete.

---
 rtl/wrr_arbiter.sv | 72 +++++++
 tb/tb_wrr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter, registered one-hot grant held until the last beat
module wrr_arbiter #(
  parameter int N = 7,
  parameter int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            arb_en,
  input  logic            grant_ready,
  input  logic            last,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;
  logic [N-1:0] r_grant;
  logic r_valid;
  logic [IW-1:0] r_id, r_ptr, w_ptr_nxt, w_win;
  logic [WW-1:0] r_used [N];
  logic [WW-1:0] w_wt, w_effw;
  logic [WW:0] w_used1;
  logic w_done, w_rot, w_arb;

  // masked search from p upward; the unmasked pass is the wrap-around fallback
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    pick = '0;
    for (int i = N-1; i >= 0; i--) if (r[i]) pick = IW'(i);
    for (int i = N-1; i >= 0; i--) if (r[i] && IW'(i) >= p) pick = IW'(i);
  endfunction

  assign w_wt = weight[r_id*WW +: WW];
  assign w_effw = (w_wt == '0) ? WW'(1) : w_wt;
  assign w_used1 = {1'b0, r_used[r_id]} + (WW+1)'(1);
  assign w_rot = w_used1 >= {1'b0, w_effw};
  assign w_done = (r_state == BUSY) && grant_ready && last;
  assign w_ptr_nxt = !w_done ? r_ptr : !w_rot ? r_id : (r_id == IW'(N-1)) ? '0 : r_id + IW'(1);
  assign w_win = pick(req, w_ptr_nxt);
  assign w_arb = arb_en && |req && (r_state == IDLE || w_done);

  always_comb w_state_nxt = w_arb ? BUSY : w_done ? IDLE : r_state;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_id <= '0;
      for (int i = 0; i < N; i++) r_used[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr <= w_ptr_nxt;
      if (w_done) r_used[r_id] <= w_rot ? '0 : w_used1[WW-1:0];
      if (w_arb) begin
        r_grant <= N'(1) << w_win;
        r_valid <= 1'b1;
        r_id <= w_win;
      end else if (w_done) begin
        r_grant <= '0;
        r_valid <= 1'b0;
        r_id <= '0;
      end
    end

  assign grant = r_grant;
  assign grant_valid = r_valid;
  assign grant_id = r_id;
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: scoreboard bench for wrr_arbiter at N=4, WW=4
module tb_wrr_arbiter;
  localparam int N = 4;
  localparam int WW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*WW-1:0] weight = 16'h1111;
  logic arb_en = 1'b0;
  logic grant_ready = 1'b0;
  logic last = 1'b0;
  logic [N-1:0] grant;
  logic grant_valid;
  logic [1:0] grant_id;
  int n_checks = 0;
  int n_fail = 0;
  int q[$];

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .weight(weight), .arb_en(arb_en),
    .grant_ready(grant_ready), .last(last), .grant(grant), .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    arb_en = 1'b0;
    grant_ready = 1'b0;
    last = 1'b0;
    weight = 16'h1111;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1111;
    arb_en = 1'b1;
    grant_ready = 1'b1;
    last = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%b valid=%b id=%0d, expected 0000/0/0", grant, grant_valid, grant_id);
    end
    rst_n = 1'b1;
    grant_ready = 1'b0;
    last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b valid=%b id=%0d, expected 0001/1/0", grant, grant_valid, grant_id);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: grant=%b valid=%b id=%0d, expected 0000/0/0", grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_equal();
    int seq[9] = '{0, 1, 2, 3, 0, 1, 2, 0, 2};
    int e, npop = 0, cyc = 0;
    logic gap = 1'b0;
    do_reset();
    weight = 16'h1111;
    req = 4'b1111;
    arb_en = 1'b1;
    grant_ready = 1'b1;
    last = 1'b1;
    foreach (seq[i]) q.push_back(seq[i]);
    while (q.size() > 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (npop > 0 && !grant_valid) gap = 1'b1;
      if (grant_valid && grant_ready) begin
        e = q.pop_front();
        npop++;
        n_checks++;
        if (grant_id !== 2'(e) || grant !== 4'(1 << e)) begin
          n_fail++;
          $display("FAIL equal_seq[%0d]: grant=%b id=%0d, expected id=%0d", npop, grant, grant_id, e);
        end
        if (npop == 7) req = 4'b0101;
      end
    end
    req = '0;
    arb_en = 1'b0;
    n_checks++;
    if (q.size() != 0 || gap) begin
      n_fail++;
      $display("FAIL equal_flow: left=%0d bubble=%b, expected left=0 bubble=0", q.size(), gap);
    end
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0 || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL equal_idle: grant=%b valid=%b, expected 0000/0", grant, grant_valid);
    end
  endtask

  task automatic test_weighted();
    int seq[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    int e, npop = 0, cyc = 0;
    do_reset();
    weight = 16'h1113;
    req = 4'b1111;
    arb_en = 1'b1;
    grant_ready = 1'b1;
    last = 1'b1;
    foreach (seq[i]) q.push_back(seq[i]);
    while (q.size() > 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (grant_valid && grant_ready) begin
        e = q.pop_front();
        npop++;
        n_checks++;
        if (grant_id !== 2'(e) || grant !== 4'(1 << e)) begin
          n_fail++;
          $display("FAIL weighted_seq[%0d]: grant=%b id=%0d, expected id=%0d", npop, grant, grant_id, e);
        end
      end
    end
    req = '0;
    arb_en = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL weighted_timeout: %0d grants missing, expected 0", q.size());
    end
  endtask

  task automatic test_lock();
    logic [3:0] rq [7] = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    logic rdy [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic lst [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int ex [7] = '{0, 0, 0, 0, 0, 0, 1};
    int e;
    do_reset();
    arb_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req = rq[k];
      grant_ready = rdy[k];
      last = lst[k];
      q.push_back(ex[k]);
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'(e) || grant !== 4'(1 << e)) begin
        n_fail++;
        $display("FAIL lock[%0d]: grant=%b valid=%b id=%0d, expected id=%0d", k, grant, grant_valid, grant_id, e);
      end
    end
    req = '0;
    arb_en = 1'b0;
    grant_ready = 1'b1;
    last = 1'b1;
  endtask

  task automatic test_weight0();
    int seq[6] = '{2, 2, 2, 2, 3, 2};
    int e, npop = 0, cyc = 0;
    do_reset();
    weight = 16'h1011;
    req = 4'b0100;
    arb_en = 1'b1;
    grant_ready = 1'b1;
    last = 1'b1;
    foreach (seq[i]) q.push_back(seq[i]);
    while (q.size() > 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (grant_valid && grant_ready) begin
        e = q.pop_front();
        npop++;
        n_checks++;
        if (grant_id !== 2'(e) || grant !== 4'(1 << e)) begin
          n_fail++;
          $display("FAIL weight0_seq[%0d]: grant=%b id=%0d, expected id=%0d", npop, grant, grant_id, e);
        end
        if (npop == 4) req = 4'b1100;
      end
    end
    req = '0;
    arb_en = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL weight0_timeout: %0d grants missing, expected 0", q.size());
    end
  endtask

  task automatic test_gating();
    logic en [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic lst [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int ex [8] = '{-1, -1, -1, 0, 0, 0, -1, -1};
    int e;
    logic [3:0] eg;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      arb_en = en[k];
      grant_ready = rdy[k];
      last = lst[k];
      q.push_back(ex[k]);
      @(negedge clk);
      e = q.pop_front();
      eg = (e < 0) ? 4'b0 : 4'(1 << e);
      n_checks++;
      if (grant !== eg || grant_valid !== (e >= 0) || grant_id !== ((e < 0) ? 2'd0 : 2'(e))) begin
        n_fail++;
        $display("FAIL gating[%0d]: grant=%b valid=%b id=%0d, expected grant=%b", k, grant, grant_valid, grant_id, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_weighted();
    test_lock();
    test_weight0();
    test_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
